alarm_trigger_ctrl: RTL and testbench

//  Downstream consumer of the alarm-time registers. Compares the stored alarm

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_time_adder.sv | 27 ++
 rtl/alarm_trigger_ctrl.sv | 137 +++++++++++++
 tb/tb_alarm_trigger_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared widths, FSM state encoding and time payload for the alarm trigger path.
package alarm_pkg;

  localparam int unsigned HOURS_W = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [HOURS_W-1:0] hours;
    logic [MIN_W-1:0]   minutes;
  } hhmm_t;

endpackage

// File: rtl/alarm_time_adder.sv
// Combinational hh:mm + ADD_MIN minutes with mod-60 minute and mod-24 hour wrap.
module alarm_time_adder
  import alarm_pkg::*;
#(
  parameter int unsigned ADD_MIN = 9
) (
  input  logic [HOURS_W-1:0] hours,
  input  logic [MIN_W-1:0]   minutes,
  output logic [HOURS_W-1:0] sum_hours_c,
  output logic [MIN_W-1:0]   sum_minutes_c
);

  localparam int unsigned SUM_W = 7;

  logic [SUM_W-1:0] min_sum;

  always_comb begin
    min_sum       = SUM_W'(minutes) + SUM_W'(ADD_MIN);
    sum_hours_c   = hours;
    sum_minutes_c = MIN_W'(min_sum);
    if (min_sum >= SUM_W'(60)) begin
      sum_minutes_c = MIN_W'(min_sum - SUM_W'(60));
      sum_hours_c   = (hours == HOURS_W'(23)) ? '0 : HOURS_W'(hours + HOURS_W'(1));
    end
  end

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// Alarm ring/snooze/stop sequencer driving the buzzer from alarm vs clock time.
// Optional BUZZER_PULSE_EN: beep pattern (toggle per second) instead of steady tone.
module alarm_trigger_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned MAX_SNOOZES      = 3
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               alarm_enable,
  input  logic [HOURS_W-1:0] alarm_hours,
  input  logic [MIN_W-1:0]   alarm_minutes,
  input  logic [HOURS_W-1:0] time_hours,
  input  logic [MIN_W-1:0]   time_minutes,
  input  logic [SEC_W-1:0]   time_seconds,
  input  logic               sec_tick,
  input  logic               snooze_btn,
  input  logic               stop_btn,
  output logic               buzzer_out,
  output logic               alarm_active,
  output logic               snooze_active,
  output logic [2:0]         snooze_count
);

  localparam int unsigned RING_W = 8;
  localparam int unsigned CNT_W  = 3;

  state_t             state, state_nxt;
  logic [RING_W-1:0]  ring_sec, ring_sec_nxt;
  logic [CNT_W-1:0]   count_nxt;
  hhmm_t              snooze_tgt, snooze_tgt_nxt;
  logic [HOURS_W-1:0] tgt_hours_c;
  logic [MIN_W-1:0]   tgt_minutes_c;
  logic               buzzer_nxt;
  logic               top_of_min, match_alarm, match_snooze, timeout;

  alarm_time_adder #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_snooze_add (
    .hours         (time_hours),
    .minutes       (time_minutes),
    .sum_hours_c   (tgt_hours_c),
    .sum_minutes_c (tgt_minutes_c)
  );

  // Second-0 qualification makes each match fire at most once per minute.
  assign top_of_min   = sec_tick & (time_seconds == '0);
  assign match_alarm  = top_of_min & (time_hours == alarm_hours)
                        & (time_minutes == alarm_minutes);
  assign match_snooze = top_of_min & (time_hours == snooze_tgt.hours)
                        & (time_minutes == snooze_tgt.minutes);
  assign timeout      = sec_tick & (ring_sec == RING_W'(RING_TIMEOUT_SEC - 1));

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ring_sec      <= '0;
      snooze_tgt    <= '0;
      snooze_count  <= '0;
      buzzer_out    <= 1'b0;
      alarm_active  <= 1'b0;
      snooze_active <= 1'b0;
    end else begin
      state         <= state_nxt;
      ring_sec      <= ring_sec_nxt;
      snooze_tgt    <= snooze_tgt_nxt;
      snooze_count  <= count_nxt;
      buzzer_out    <= buzzer_nxt;
      alarm_active  <= (state_nxt == ST_RINGING);
      snooze_active <= (state_nxt == ST_SNOOZE);
    end
  end

  // Priority: !alarm_enable > stop_btn > timeout > snooze_btn > match.
  always_comb begin
    state_nxt      = state;
    ring_sec_nxt   = ring_sec;
    count_nxt      = snooze_count;
    snooze_tgt_nxt = snooze_tgt;
    buzzer_nxt     = 1'b0;

    if (!alarm_enable) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (match_alarm) begin
            state_nxt    = ST_RINGING;
            ring_sec_nxt = '0;
          end
        end
        ST_RINGING: begin
          if (stop_btn || timeout) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
          end else begin
            if (sec_tick) ring_sec_nxt = RING_W'(ring_sec + RING_W'(1));
            if (snooze_btn && (snooze_count < CNT_W'(MAX_SNOOZES))) begin
              state_nxt              = ST_SNOOZE;
              count_nxt              = CNT_W'(snooze_count + CNT_W'(1));
              snooze_tgt_nxt.hours   = tgt_hours_c;
              snooze_tgt_nxt.minutes = tgt_minutes_c;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_btn) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
          end else if (match_snooze) begin
            state_nxt    = ST_RINGING;
            ring_sec_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end
      endcase
    end

`ifdef BUZZER_PULSE_EN
    // Beep starts on at ring entry, then flips every second while ringing.
    if (state_nxt == ST_RINGING) begin
      if (state != ST_RINGING) buzzer_nxt = 1'b1;
      else if (sec_tick)       buzzer_nxt = ~buzzer_out;
      else                     buzzer_nxt = buzzer_out;
    end
`else
    buzzer_nxt = (state_nxt == ST_RINGING);
`endif
  end

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// Self-checking bench for alarm_trigger_ctrl: directed scenarios plus random run vs a time-of-day model.
module tb_alarm_trigger_ctrl;

  localparam int unsigned SNOOZE_MIN       = 9;
  localparam int unsigned RING_TIMEOUT_SEC = 60;
  localparam int unsigned MAX_SNOOZES      = 3;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       alarm_enable;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [5:0] time_seconds;
  logic       sec_tick;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer_out;
  logic       alarm_active;
  logic       snooze_active;
  logic [2:0] snooze_count;
  logic [5:0] obs;

  int errors = 0;
  int checks = 0;
  int tod    = 0;

  // Reference model: mode 0 quiet, 1 ringing, 2 snoozed; target in minutes of day.
  int m_mode, m_count, m_heard, m_target;

  alarm_trigger_ctrl #(
    .SNOOZE_MIN       (SNOOZE_MIN),
    .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC),
    .MAX_SNOOZES      (MAX_SNOOZES)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .alarm_enable  (alarm_enable),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .time_hours    (time_hours),
    .time_minutes  (time_minutes),
    .time_seconds  (time_seconds),
    .sec_tick      (sec_tick),
    .snooze_btn    (snooze_btn),
    .stop_btn      (stop_btn),
    .buzzer_out    (buzzer_out),
    .alarm_active  (alarm_active),
    .snooze_active (snooze_active),
    .snooze_count  (snooze_count)
  );

  always #5 sys_clk = ~sys_clk;

  assign obs = {buzzer_out, alarm_active, snooze_active, snooze_count};

  function automatic logic [5:0] exp_vec();
    logic ring, buzz;
    ring = (m_mode == 1);
`ifdef BUZZER_PULSE_EN
    buzz = ring && (m_heard % 2 == 0);
`else
    buzz = ring;
`endif
    return {buzz, ring, logic'(m_mode == 2), 3'(m_count)};
  endfunction

  task automatic model_step(input bit tick);
    int  now_min;
    bit  top;
    now_min = tod / 60;
    top     = tick && (tod % 60 == 0);
    if (!alarm_enable) begin
      m_mode = 0; m_count = 0;
    end else if (m_mode == 0) begin
      if (top && now_min == int'(alarm_hours) * 60 + int'(alarm_minutes)) begin
        m_mode = 1; m_heard = 0;
      end
    end else if (m_mode == 1) begin
      if (stop_btn || (tick && m_heard + 1 >= int'(RING_TIMEOUT_SEC))) begin
        m_mode = 0; m_count = 0;
      end else begin
        if (tick) m_heard++;
        if (snooze_btn && m_count < int'(MAX_SNOOZES)) begin
          m_mode = 2; m_count++;
          m_target = (now_min + int'(SNOOZE_MIN)) % 1440;
        end
      end
    end else begin
      if (stop_btn) begin
        m_mode = 0; m_count = 0;
      end else if (top && now_min == m_target) begin
        m_mode = 1; m_heard = 0;
      end
    end
  endtask

  // One clock: optional second advance, drive inputs, update model, settle past the edge.
  task automatic cycle(input bit tick, input bit snz, input bit stp);
    if (tick) tod = (tod + 1) % 86400;
    time_hours   = 5'(tod / 3600);
    time_minutes = 6'((tod / 60) % 60);
    time_seconds = 6'(tod % 60);
    sec_tick     = tick;
    snooze_btn   = snz;
    stop_btn     = stp;
    if (!rst_n) begin
      m_mode = 0; m_count = 0; m_heard = 0; m_target = 0;
    end else begin
      model_step(tick);
    end
    @(posedge sys_clk);
    #1;
    sec_tick   = 1'b0;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
  endtask

  task automatic set_alarm(input int h, input int m);
    alarm_hours   = 5'(h);
    alarm_minutes = 6'(m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%b want=%b", i, obs, 6'b0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ring_and_snooze();
    alarm_enable = 1'b1;
    set_alarm(6, 30);
    tod = 6 * 3600 + 29 * 60 + 55;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ring_entry t=%0d got=%b want=%b", tod, obs, exp_vec());
      end
      if (tod == 6 * 3600 + 30 * 60) begin
        checks++;
        if (alarm_active !== 1'b1 || buzzer_out !== 1'b1) begin
          errors++;
          $display("FAIL ring_at_0630 got active=%b buzz=%b want 1,1", alarm_active, buzzer_out);
        end
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (snooze_active !== 1'b1 || snooze_count !== 3'd1 || alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL snooze_enter got snz=%b cnt=%0d act=%b want 1,1,0", snooze_active, snooze_count, alarm_active);
    end
    for (int i = 0; i < 700 && tod != 6 * 3600 + 39 * 60; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL snooze_wait t=%0d got=%b want=%b", tod, obs, exp_vec());
      end
    end
    checks++;
    if (alarm_active !== 1'b1 || snooze_count !== 3'd1 || tod != 6 * 3600 + 39 * 60) begin
      errors++;
      $display("FAIL snooze_rering t=%0d got act=%b cnt=%0d want act=1 cnt=1 at 06:39:00", tod, alarm_active, snooze_count);
    end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL stop_after_rering got=%b want=%b", obs, 6'b0);
    end
  endtask

  task automatic test_timeout();
    set_alarm(6, 30);
    tod = 6 * 3600 + 29 * 60 + 59;
    for (int i = 1; i <= 70; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_model tick=%0d got=%b want=%b", i, obs, exp_vec());
      end
      if (i == 60 || i == 61) begin
        checks++;
        if (alarm_active !== logic'(i == 60)) begin
          errors++;
          $display("FAIL timeout_edge tick=%0d got=%b want=%b", i, alarm_active, logic'(i == 60));
        end
      end
    end
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL timeout_idle got=%b want=%b", obs, 6'b0);
    end
    // Stop within the alarm minute must not retrigger before 06:31.
    tod = 6 * 3600 + 29 * 60 + 59;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (alarm_active !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL no_retrigger t=%0d got=%b want=%b", tod, obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap_and_limit();
    int want;
    set_alarm(23, 55);
    tod = 23 * 3600 + 54 * 60 + 59;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (snooze_active !== 1'b1 || snooze_count !== 3'(k)) begin
        errors++;
        $display("FAIL snooze_n k=%0d got snz=%b cnt=%0d", k, snooze_active, snooze_count);
      end
      if (k == 1) set_alarm(0, 0);
      want = ((23 * 60 + 55 + 9 * k) % 1440) * 60;
      for (int i = 0; i < 700 && tod != want; i++) begin
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL wrap_wait k=%0d t=%0d got=%b want=%b", k, tod, obs, exp_vec());
        end
      end
      checks++;
      if (alarm_active !== 1'b1 || tod != want) begin
        errors++;
        $display("FAIL wrap_rering k=%0d t=%0d got act=%b want 1 at t=%0d", k, tod, alarm_active, want);
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (alarm_active !== 1'b1 || snooze_active !== 1'b0 || snooze_count !== 3'd3) begin
      errors++;
      $display("FAIL snooze_limit got act=%b snz=%b cnt=%0d want 1,0,3", alarm_active, snooze_active, snooze_count);
    end
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_buttons_enable();
    set_alarm(7, 0);
    tod = 6 * 3600 + 59 * 60 + 59;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL stop_beats_snooze got=%b want=%b", obs, 6'b0);
    end
    set_alarm(7, 1);
    tod = 7 * 3600 + 0 * 60 + 59;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    alarm_enable = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL enable_drop got=%b want=%b", obs, 6'b0);
    end
    alarm_enable = 1'b1;
    tod = 7 * 3600 + 9 * 60 + 55;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL no_ring_at_target t=%0d got=%b want=%b", tod, obs, 6'b0);
      end
    end
  endtask

  task automatic test_buzzer_and_reset();
    logic want;
    set_alarm(9, 0);
    tod = 8 * 3600 + 59 * 60 + 59;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
`ifdef BUZZER_PULSE_EN
      want = logic'(i % 2 == 0);
`else
      want = 1'b1;
`endif
      checks++;
      if (buzzer_out !== want) begin
        errors++;
        $display("FAIL buzzer_pattern tick=%0d got=%b want=%b", i, buzzer_out, want);
      end
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (buzzer_out !== want) begin
        errors++;
        $display("FAIL buzzer_hold tick=%0d got=%b want=%b", i, buzzer_out, want);
      end
    end
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_ring got=%b want=%b", obs, 6'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL post_reset_quiet t=%0d got=%b want=%b", tod, obs, 6'b0);
      end
    end
  endtask

  task automatic test_random();
    bit tk, sz, sp;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) begin
        set_alarm((tod / 3600 + 1) % 24, $urandom_range(59));
        tod = int'(alarm_hours) * 3600 + int'(alarm_minutes) * 60 - 3;
      end
      if (m_mode == 2 && $urandom_range(39) == 0)
        tod = (m_target * 60 + 86400 - 2) % 86400;
      if ($urandom_range(99) == 0) set_alarm($urandom_range(23), $urandom_range(59));
      alarm_enable = ($urandom_range(199) != 0);
      tk = ($urandom_range(3) != 0);
      sz = ($urandom_range(19) == 0);
      sp = ($urandom_range(59) == 0);
      cycle(tk, sz, sp);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random i=%0d t=%0d got=%b want=%b", i, tod, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    alarm_enable = 1'b0;
    set_alarm(0, 0);
    time_hours   = '0;
    time_minutes = '0;
    time_seconds = '0;
    sec_tick     = 1'b0;
    snooze_btn   = 1'b0;
    stop_btn     = 1'b0;
    m_mode = 0; m_count = 0; m_heard = 0; m_target = 0;

    test_reset();
    test_ring_and_snooze();
    test_timeout();
    test_wrap_and_limit();
    test_buttons_enable();
    test_buzzer_and_reset();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
